// File: rtl/vga_pkg.sv
// Shared raster timing defaults and control-bundle types for the VGA controller
// and the video memory that feeds it.
package vga_pkg;

    localparam int H_DISP_DEF   = 640;
    localparam int H_FP_DEF     = 16;
    localparam int H_SYNC_DEF   = 96;
    localparam int H_BP_DEF     = 48;
    localparam int V_DISP_DEF   = 480;
    localparam int V_FP_DEF     = 10;
    localparam int V_SYNC_DEF   = 2;
    localparam int V_BP_DEF     = 33;
    localparam int DATA_LAT_DEF = 3;

    localparam int HT_DEF = H_DISP_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
    localparam int VT_DEF = V_DISP_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

    localparam int ADDR_W = 10;
    localparam int RGB_W  = 24;

    // Per-pixel control flags carried alongside the memory read latency.
    typedef struct packed {
        logic act;
        logic hs;
        logic vs;
    } ctl_t;

    localparam int CTL_W = $bits(ctl_t);

    // Blanked, sync-inactive pattern used to flush the delay line.
    localparam ctl_t CTL_RST = '{act: 1'b0, hs: 1'b1, vs: 1'b1};

    // Half-open window test: lo <= cnt < hi.
    function automatic logic in_window(
        input logic [ADDR_W-1:0] cnt,
        input logic [ADDR_W-1:0] lo,
        input logic [ADDR_W-1:0] hi
    );
        return (cnt >= lo) && (cnt < hi);
    endfunction

endpackage

// File: rtl/vga_if.sv
// Video bus between the raster controller, the video memory and the display port.
interface vga_if;
    import vga_pkg::*;

    logic [ADDR_W-1:0] h_addr;
    logic [ADDR_W-1:0] v_addr;
    logic [RGB_W-1:0]  vga_data;
    logic              hsync;
    logic              vsync;
    logic              valid;
    logic [7:0]        vga_r;
    logic [7:0]        vga_g;
    logic [7:0]        vga_b;
    logic              frame_start;

    modport master (
        output h_addr,
        output v_addr,
        input  vga_data,
        output hsync,
        output vsync,
        output valid,
        output vga_r,
        output vga_g,
        output vga_b,
        output frame_start
    );

    modport slave (
        input  h_addr,
        input  v_addr,
        output vga_data,
        input  hsync,
        input  vsync,
        input  valid,
        input  vga_r,
        input  vga_g,
        input  vga_b,
        input  frame_start
    );

endinterface

// File: rtl/vga_delay.sv
// Fixed-depth shift register that keeps control flags in step with memory read
// latency; DEPTH=0 is a plain wire.
module vga_delay #(
    parameter int WIDTH = 3,
    parameter int DEPTH = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] rst_val,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    generate
        if (DEPTH == 0) begin : g_bypass
            logic unused_s;
            assign unused_s = ^{clk, rst, rst_val};
            assign dout     = din;
        end else begin : g_pipe
            logic [WIDTH-1:0] stage_r [DEPTH];

            // Shift flags one stage per clock; reset loads the caller's idle pattern.
            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        stage_r[i] <= rst_val;
                    end
                end else begin
                    stage_r[0] <= din;
                    for (int i = 1; i < DEPTH; i++) begin
                        stage_r[i] <= stage_r[i-1];
                    end
                end
            end

            assign dout = stage_r[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/vga_ctrl.sv
// Raster timing generator: pixel/line counters, active-area addressing and a
// latency-matched output stage pairing sync/valid with returned pixel data.
module vga_ctrl
    import vga_pkg::*;
#(
    parameter int H_DISP   = H_DISP_DEF,
    parameter int H_FP     = H_FP_DEF,
    parameter int H_SYNC   = H_SYNC_DEF,
    parameter int H_BP     = H_BP_DEF,
    parameter int V_DISP   = V_DISP_DEF,
    parameter int V_FP     = V_FP_DEF,
    parameter int V_SYNC   = V_SYNC_DEF,
    parameter int V_BP     = V_BP_DEF,
    parameter int DATA_LAT = DATA_LAT_DEF
) (
    input  logic  clk,
    input  logic  rst,
    vga_if.master bus
);

    localparam int HT = H_DISP + H_FP + H_SYNC + H_BP;
    localparam int VT = V_DISP + V_FP + V_SYNC + V_BP;

    localparam logic [ADDR_W-1:0] H_DISP_C   = ADDR_W'(H_DISP);
    localparam logic [ADDR_W-1:0] H_LAST_C   = ADDR_W'(HT - 1);
    localparam logic [ADDR_W-1:0] HS_START_C = ADDR_W'(H_DISP + H_FP);
    localparam logic [ADDR_W-1:0] HS_END_C   = ADDR_W'(H_DISP + H_FP + H_SYNC);
    localparam logic [ADDR_W-1:0] V_DISP_C   = ADDR_W'(V_DISP);
    localparam logic [ADDR_W-1:0] V_LAST_C   = ADDR_W'(VT - 1);
    localparam logic [ADDR_W-1:0] VS_START_C = ADDR_W'(V_DISP + V_FP);
    localparam logic [ADDR_W-1:0] VS_END_C   = ADDR_W'(V_DISP + V_FP + V_SYNC);

    logic [ADDR_W-1:0] h_cnt_r;
    logic [ADDR_W-1:0] v_cnt_r;
    logic              act_raw_s;
    ctl_t              raw_s;
    ctl_t              dly_s;
    logic [ADDR_W-1:0] h_addr_s;
    logic [ADDR_W-1:0] v_addr_s;
    logic              frame_start_s;
    logic              hsync_r;
    logic              vsync_r;
    logic              valid_r;
    logic [RGB_W-1:0]  rgb_r;

    // Pixel and line counters; the line counter steps only on pixel wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            h_cnt_r <= {ADDR_W{1'b0}};
            v_cnt_r <= {ADDR_W{1'b0}};
        end else if (h_cnt_r == H_LAST_C) begin
            h_cnt_r <= {ADDR_W{1'b0}};
            if (v_cnt_r == V_LAST_C) begin
                v_cnt_r <= {ADDR_W{1'b0}};
            end else begin
                v_cnt_r <= v_cnt_r + 10'd1;
            end
        end else begin
            h_cnt_r <= h_cnt_r + 10'd1;
        end
    end

    // Decode active area and sync windows from the current counter position.
    always_comb begin
        raw_s     = CTL_RST;
        act_raw_s = (h_cnt_r < H_DISP_C) && (v_cnt_r < V_DISP_C);
        raw_s.act = act_raw_s;
        raw_s.hs  = ~in_window(h_cnt_r, HS_START_C, HS_END_C);
        raw_s.vs  = ~in_window(v_cnt_r, VS_START_C, VS_END_C);
    end

    // Memory addresses and frame marker are undelayed; held at zero during reset.
    always_comb begin
        h_addr_s      = {ADDR_W{1'b0}};
        v_addr_s      = {ADDR_W{1'b0}};
        frame_start_s = 1'b0;
        if (rst) begin
            h_addr_s      = {ADDR_W{1'b0}};
            v_addr_s      = {ADDR_W{1'b0}};
            frame_start_s = 1'b0;
        end else begin
            if (act_raw_s) begin
                h_addr_s = h_cnt_r;
                v_addr_s = v_cnt_r;
            end else begin
                h_addr_s = {ADDR_W{1'b0}};
                v_addr_s = {ADDR_W{1'b0}};
            end
            frame_start_s = (h_cnt_r == 10'd0) && (v_cnt_r == 10'd0);
        end
    end

    vga_delay #(
        .WIDTH (CTL_W),
        .DEPTH (DATA_LAT)
    ) u_delay (
        .clk     (clk),
        .rst     (rst),
        .rst_val (CTL_RST),
        .din     (raw_s),
        .dout    (dly_s)
    );

    // Output register: flags arrive together with the pixel they describe, so
    // vga_data is only sampled when the delayed active flag is set.
    always_ff @(posedge clk) begin
        if (rst) begin
            hsync_r <= 1'b1;
            vsync_r <= 1'b1;
            valid_r <= 1'b0;
            rgb_r   <= 24'h000000;
        end else begin
            hsync_r <= dly_s.hs;
            vsync_r <= dly_s.vs;
            valid_r <= dly_s.act;
            rgb_r   <= dly_s.act ? bus.vga_data : 24'h000000;
        end
    end

    assign bus.h_addr      = h_addr_s;
    assign bus.v_addr      = v_addr_s;
    assign bus.frame_start = frame_start_s;
    assign bus.hsync       = hsync_r;
    assign bus.vsync       = vsync_r;
    assign bus.valid       = valid_r;
    assign bus.vga_r       = rgb_r[23:16];
    assign bus.vga_g       = rgb_r[15:8];
    assign bus.vga_b       = rgb_r[7:0];

endmodule
